// File: rtl/fft_pipe_ctrl_if.sv
// Block handshake bundle between the FFT sequencer and its neighbours.
//
// Valid/ready semantics (both directions):
//   - A block transfers on a rising clock edge where valid and ready are both 1.
//   - The source holds valid (and its block) stable until it transfers, unless
//     the sequencer is flushed by its synchronous clear.
//   - The input side may drop din_valid between blocks (gaps are legal).
//   - din_ready is a combinational function of dout_valid, dout_ready and the
//     synchronous clear, so the upstream must not make din_valid depend on
//     din_ready combinationally.
interface fft_pipe_ctrl_if;
    logic din_valid;
    logic din_ready;
    logic dout_valid;
    logic dout_ready;
    logic dout_sof;
    logic dout_eof;

    // master: the environment that sources input blocks and sinks output blocks
    modport master (
        output din_valid,
        output dout_ready,
        input  din_ready,
        input  dout_valid,
        input  dout_sof,
        input  dout_eof
    );

    // slave: the sequencer itself
    modport slave (
        input  din_valid,
        input  dout_ready,
        output din_ready,
        output dout_valid,
        output dout_sof,
        output dout_eof
    );
endinterface

// File: rtl/fft_pipe_ctrl.sv
// Sequencer for the parallel-radix FFT datapath.
// Tracks a valid bit and a block index per registered datapath stage, drives
// the per-stage register enables and the twiddle block select, freezes the
// whole chain when the output is backpressured and supports a synchronous
// flush that restarts frame numbering.
module fft_pipe_ctrl #(
    parameter int N_STAGE  = 6,
    parameter int N_BLK    = 4,
    parameter int TW_STAGE = 1,
    parameter int FCNT_W   = 16,
    localparam int BLK_W   = (N_BLK > 1) ? $clog2(N_BLK) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync_clr_i,
    fft_pipe_ctrl_if.slave      bus,
    output logic [N_STAGE-1:0]  stage_en_o,
    output logic [BLK_W-1:0]    tw_blk_o,
    output logic [FCNT_W-1:0]   frame_cnt_o,
    output logic                abort_err_o
);

    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(N_BLK - 1);

    // Per-stage tracking state: vld_q[k]/blk_q[k] describe the data held in
    // datapath stage k's output register.
    logic [N_STAGE-1:0] vld_q, vld_d;
    logic [BLK_W-1:0]   blk_q [N_STAGE];
    logic [BLK_W-1:0]   blk_d [N_STAGE];
    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic               abort_err_q, abort_err_d;

    logic stall;
    logic accept;
    logic in_flight;

    // A valid block at the output that is not taken freezes every stage.
    // Bubbles inside the chain do not stall; they simply shift along.
    assign stall     = vld_q[N_STAGE-1] & ~bus.dout_ready;
    assign bus.din_ready = ~stall & ~sync_clr_i;
    // Gated with rst_n so that no stage enable pulses while reset is held.
    assign accept    = bus.din_valid & bus.din_ready & rst_n;
    // A clear that hits a partially received or partially drained frame.
    assign in_flight = (blk_cnt_q != '0) | (|vld_q);

    // Stage enables: a stage is clocked only when its input carries a block
    // and the chain is moving; the first stage is clocked by input accept.
    always_comb begin
        stage_en_o    = '0;
        stage_en_o[0] = accept;
        for (int k = 1; k < N_STAGE; k++) begin
            stage_en_o[k] = vld_q[k-1] & ~stall & ~sync_clr_i;
        end
    end

    // Next-state: flush on clear, shift on ~stall, hold otherwise.
    always_comb begin
        vld_d       = vld_q;
        blk_cnt_d   = blk_cnt_q;
        frame_cnt_d = frame_cnt_q;
        abort_err_d = abort_err_q;
        for (int k = 0; k < N_STAGE; k++) begin
            blk_d[k] = blk_q[k];
        end

        if (sync_clr_i) begin
            // Flush wins over stall: a held output block is dropped and the
            // frame counter does not see it.
            vld_d     = '0;
            blk_cnt_d = '0;
            if (in_flight) begin
                abort_err_d = 1'b1;
            end
        end else if (!stall) begin
            vld_d[0] = accept;
            blk_d[0] = blk_cnt_q;
            for (int k = 1; k < N_STAGE; k++) begin
                vld_d[k] = vld_q[k-1];
                blk_d[k] = blk_q[k-1];
            end
            if (accept) begin
                blk_cnt_d = (blk_cnt_q == LAST_BLK) ? '0 : blk_cnt_q + BLK_W'(1);
            end
            // An EOF block that leaves the chain completes one frame.
            if (bus.dout_eof & bus.dout_ready) begin
                frame_cnt_d = frame_cnt_q + FCNT_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            blk_cnt_q   <= '0;
            frame_cnt_q <= '0;
            abort_err_q <= 1'b0;
            for (int k = 0; k < N_STAGE; k++) begin
                blk_q[k] <= '0;
            end
        end else begin
            vld_q       <= vld_d;
            blk_cnt_q   <= blk_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            abort_err_q <= abort_err_d;
            for (int k = 0; k < N_STAGE; k++) begin
                blk_q[k] <= blk_d[k];
            end
        end
    end

    // Output-side frame position flags come from the last stage's tag.
    assign bus.dout_valid = vld_q[N_STAGE-1];
    assign bus.dout_sof   = vld_q[N_STAGE-1] & (blk_q[N_STAGE-1] == '0);
    assign bus.dout_eof   = vld_q[N_STAGE-1] & (blk_q[N_STAGE-1] == LAST_BLK);

    // Twiddle select: block index presented at the input of stage TW_STAGE.
    generate
        if (TW_STAGE == 0) begin : g_tw_in
            assign tw_blk_o = blk_cnt_q;
        end else begin : g_tw_stage
            assign tw_blk_o = blk_q[TW_STAGE-1];
        end
    endgenerate

    assign frame_cnt_o = frame_cnt_q;
    assign abort_err_o = abort_err_q;

endmodule

// File: tb/tb_fft_pipe_ctrl.sv
// Directed testbench for fft_pipe_ctrl with a small output scoreboard.
module tb_fft_pipe_ctrl;

  localparam int N_STAGE  = 6;
  localparam int N_BLK    = 4;
  localparam int TW_STAGE = 1;
  localparam int FCNT_W   = 4;
  localparam int W        = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic sync_clr;
  logic [N_STAGE-1:0] stage_en;
  logic [W-1:0] tw_blk;
  logic [FCNT_W-1:0] frame_cnt;
  logic abort_err;

  always #5 clk = ~clk;

  fft_pipe_ctrl_if bus ();

  fft_pipe_ctrl #(
    .N_STAGE  (N_STAGE),
    .N_BLK    (N_BLK),
    .TW_STAGE (TW_STAGE),
    .FCNT_W   (FCNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_clr_i  (sync_clr),
    .bus         (bus),
    .stage_en_o  (stage_en),
    .tw_blk_o    (tw_blk),
    .frame_cnt_o (frame_cnt),
    .abort_err_o (abort_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic drive(input logic dv, input logic dr, input logic sc);
    @(posedge clk);
    #1;
    bus.din_valid  = dv;
    bus.dout_ready = dr;
    sync_clr       = sc;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    bus.din_valid  = 1'b1;
    bus.dout_ready = 1'b0;
    sync_clr       = 1'b0;
    #1;
    check("rst_din_ready", bus.din_ready, 1);
    check("rst_stage_en", stage_en, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_sof_eof", {bus.dout_sof, bus.dout_eof}, 0);
    check("rst_tw_blk", tw_blk, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_abort_err", abort_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n          = 1'b1;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
  endtask

  // Stall-free pattern run: pat bit t = block offered in cycle t.
  // vmask/sofm/eofm are hand-derived output cycles.
  task automatic run_pattern(input string name, input logic [31:0] pat,
                             input logic [31:0] vmask, input logic [31:0] sofm,
                             input logic [31:0] eofm, input int ncyc, input int fexp);
    logic [N_STAGE-1:0] exp_en;
    int twi;
    twi = 0;
    for (int t = 0; t < ncyc; t++) begin
      drive(pat[t], 1'b1, 1'b0);
      exp_en = '0;
      for (int k = 0; k < N_STAGE; k++) begin
        if (t >= k) exp_en[k] = pat[t-k];
      end
      check({name, "_stage_en"}, stage_en, exp_en);
      check({name, "_dout_valid"}, bus.dout_valid, vmask[t]);
      check({name, "_sof"}, bus.dout_sof, sofm[t]);
      check({name, "_eof"}, bus.dout_eof, eofm[t]);
      if (t >= 1 && pat[t-1]) begin
        check({name, "_tw_blk"}, tw_blk, twi % N_BLK);
        twi++;
      end
    end
    check({name, "_frame_cnt"}, frame_cnt, fexp);
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_blk;

  initial begin
    logic [W-1:0] e;
    sb_blk = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || sync_clr) begin
        exp_q.delete();
        sb_blk = '0;
      end else begin
        if (bus.dout_valid && bus.dout_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("sb_sof", bus.dout_sof, (e == 0));
            check("sb_eof", bus.dout_eof, (e == W'(N_BLK - 1)));
          end
        end
        if (bus.din_valid && bus.din_ready) begin
          exp_q.push_back(sb_blk);
          sb_blk = sb_blk + 2'd1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    rst_n          = 1'b0;
    bus.din_valid  = 1'b1;
    bus.dout_ready = 1'b0;
    sync_clr       = 1'b0;
    #2;
    check("init_din_ready", bus.din_ready, 1);
    check("init_stage_en", stage_en, 0);
    check("init_dout_valid", bus.dout_valid, 0);
    check("init_frame_cnt", frame_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n          = 1'b1;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;

    // 4 consecutive blocks: outputs 6..9, sof 6, eof 9
    run_pattern("contig", 32'h0000_000F, 32'h0000_03C0, 32'h0000_0040, 32'h0000_0200, 12, 1);
    // Gapped blocks at 0,2,3,7: outputs 6,8,9,13
    run_pattern("gaps", 32'h0000_008D, 32'h0000_2340, 32'h0000_0040, 32'h0000_2000, 16, 2);

    // 8 blocks with dout_ready low for cycles 6..8
    acc = 0;
    for (int t = 0; t < 20; t++) begin
      drive(acc < 8, !(t >= 6 && t <= 8), 1'b0);
      if (t >= 6 && t <= 8) begin
        check("stall_din_ready", bus.din_ready, 0);
        check("stall_stage_en", stage_en, 0);
        check("stall_held_sof", bus.dout_sof, 1);
      end
      check("stall_dout_valid", bus.dout_valid, (t >= 6 && t <= 16));
      if (bus.din_valid && bus.din_ready) acc++;
    end
    check("stall_accepts", acc, 8);
    check("stall_frame_cnt", frame_cnt, 4);
    check("stall_sb_empty", exp_q.size(), 0);

    // Abort with a partial frame in flight
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    check("abort_stage_en", stage_en, 0);
    check("abort_din_ready", bus.din_ready, 0);
    for (int t = 0; t < 8; t++) begin
      drive(1'b0, 1'b1, 1'b0);
      check("abort_flushed", bus.dout_valid, 0);
    end
    check("abort_err_set", abort_err, 1);
    check("abort_frame_cnt", frame_cnt, 4);
    drive(1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= 6; t++) drive(1'b0, 1'b1, 1'b0);
    check("abort_next_valid", bus.dout_valid, 1);
    check("abort_next_sof", bus.dout_sof, 1);
    check("abort_next_eof", bus.dout_eof, 0);
    check("abort_frame_cnt2", frame_cnt, 4);

    // Reset clears sticky abort_err; then clear on an idle pipeline
    do_reset();
    drive(1'b1, 1'b1, 1'b1);
    check("idleclr_din_ready", bus.din_ready, 0);
    check("idleclr_stage_en", stage_en, 0);
    drive(1'b0, 1'b1, 1'b0);
    check("idleclr_no_accept", stage_en, 0);
    check("idleclr_abort_err", abort_err, 0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    check("idleclr_tw_blk", tw_blk, 0);
    check("idleclr_stage_en1", stage_en, 6'b000010);
    for (int t = 2; t <= 6; t++) drive(1'b0, 1'b1, 1'b0);
    check("idleclr_sof", bus.dout_sof, 1);

    // 17 frames back to back: frame counter wraps 15 -> 0 -> 1
    do_reset();
    for (int t = 0; t < 76; t++) begin
      drive(t < 68, 1'b1, 1'b0);
      if (t >= 1 && t <= 68) check("wrap_tw_blk", tw_blk, (t - 1) % N_BLK);
      if (t == 69) check("wrap_frame_15", frame_cnt, 15);
      if (t == 70) check("wrap_frame_0", frame_cnt, 0);
    end
    check("wrap_frame_1", frame_cnt, 1);
    check("wrap_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_pipe_ctrl.md
Name: fft_pipe_ctrl

Overview:
- Sequencer for the parallel-radix FFT datapath: 16 lanes of I/Q per cycle pass through a chain of registered butterfly/twiddle stages, each with its own enable.
- Tracks the valid of each in-flight block and its frame position (SOF/EOF/block index).
- Drives per-stage enables and the twiddle block select.
- Applies downstream backpressure by freezing the whole chain, and supports synchronous abort.

Parameters:
- N_STAGE, 6, number of registered datapath stages controlled (stage latency 1 cycle each).
- N_BLK, 4, 16-lane blocks per FFT frame (64-point default).
- TW_STAGE, 1, stage index whose input block needs the twiddle select.
- FCNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sync_clr  in  1  synchronous abort: flush pipeline, restart frame.
- din_valid  in  1  a 16-lane input block is presented.
- din_ready  out  1  block accepted when din_valid & din_ready.
- dout_ready  in  1  downstream can take the output block.
- stage_en  out  N_STAGE  per-stage register enable to the datapath (bit 0 = first butterfly).
- tw_blk  out  clog2(N_BLK)  block index of data at the input of stage TW_STAGE.
- dout_valid  out  1  output block of the last stage is valid.
- dout_sof  out  1  output block is block 0 of its frame.
- dout_eof  out  1  output block is block N_BLK-1 of its frame.
- frame_cnt  out  FCNT_W  count of frames completed at output (wraps).
- abort_err  out  1  sticky: sync_clr hit with a partial frame in flight.

Behaviour:
- Reset (rst_n low, asynchronous): all vld/tag regs 0, blk_cnt 0, frame_cnt 0, abort_err 0.
  - Outputs during reset: stage_en 0, dout_valid/sof/eof 0, tw_blk 0, din_ready 1.
- Pipeline state per stage k: vld[k] and blk[k] (block index); vld[N_STAGE-1] = dout_valid.
- stall = dout_valid & ~dout_ready.
- din_ready = ~stall & ~sync_clr (combinational).
- Accept = din_valid & din_ready.
- stage_en[0] = accept; stage_en[k] = vld[k-1] & ~stall for k>=1 (stages with invalid input are not clocked).
- When ~stall (and ~sync_clr): vld[0] <= accept, blk[0] <= blk_cnt; vld[k] <= vld[k-1], blk[k] <= blk[k-1]. Bubbles propagate as vld=0.
- On stall: all vld/blk hold; all stage_en 0. Latency accept -> dout_valid is exactly N_STAGE cycles with no stalls; each stall cycle adds 1.
- blk_cnt: increments on accept, wraps N_BLK-1 -> 0.
- Outputs:
  - dout_sof = dout_valid & (blk[N_STAGE-1]==0); dout_eof = dout_valid & (blk[N_STAGE-1]==N_BLK-1).
  - tw_blk = blk_cnt when TW_STAGE==0, else blk[TW_STAGE-1]; value is don't-care when that stage input is invalid.
- frame_cnt increments when dout_eof & dout_ready; wraps at 2^FCNT_W.
- sync_clr (registered action): all vld 0, blk_cnt 0, input not accepted that cycle, stage_en 0 that cycle; frame_cnt unchanged.
  - Sets abort_err if blk_cnt!=0 or any vld is 1; abort_err clears only on rst_n.
  - sync_clr overrides stall; an output block held under stall is discarded.
- Boundary cases:
  - Back-to-back frames: block 0 of frame n+1 follows EOF of frame n with no gap.
  - Input gaps mid-frame are legal; frame position is kept.
  - dout_ready low with dout_valid 0 does not stall (bubbles are squeezed out only at the output).

Test Plan:
- Reset then 4 consecutive accepted blocks, dout_ready=1 -> stage_en[0] high for cycles 0-3; dout_valid on cycles 6-9; sof on cycle 6, eof on cycle 9; frame_cnt=1 on cycle 10.
- Blocks on cycles 0,2,3,7 (gaps) -> dout_valid on cycles 6,8,9,13; sof on 6, eof on 13; stage_en[k] pulses only where vld[k-1]=1.
- 8 back-to-back blocks; dout_ready low for 3 cycles starting when first output appears -> din_ready low those 3 cycles, stage_en all 0, dout block held; 8 outputs in order with sof at output 1 and 5, eof at output 4 and 8; frame_cnt=2.
- 2 blocks accepted, then sync_clr pulse -> pipeline empties (no dout_valid afterwards); abort_err=1; next accepted block reaches output with dout_sof=1; frame_cnt unchanged.
- sync_clr with din_valid=1 in the same cycle, pipeline idle -> din_ready=0, block not accepted; abort_err stays 0; next block gets blk index 0.
- Run 2^FCNT_W+1 frames (FCNT_W=4 override) -> frame_cnt wraps to 1. With TW_STAGE=1 -> tw_blk sequences 0,1,2,3 one cycle after each accept.
